// File: rtl/rijndael_key_pkg.sv
// Shared types and limits for the Rijndael key-schedule front stage.
package rijndael_key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        LAST  = 2'd2,
        ERR   = 2'd3
    } state_e;

    localparam int SUPPORTED_KC = 4;
    localparam int SUPPORTED_BC = 4;
    localparam int MAX_ROUNDS   = 14;
    localparam int NUM_COLS     = 4;
    localparam int DATA_W       = 32;

endpackage

// File: rtl/first_round_key.sv
// Latches the cipher key and writes W0..W3 into Ke row 0 and Kd row iRound, then hands off W3.
// Latency: writes on the 1st..4th cycle after iStart, oDone/oLast_key_data_valid on the 5th.
// Backpressure: none; iStart while busy is dropped, not queued.
module first_round_key #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_COLS = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [3:0]        iKC,
    input  logic [3:0]        iBC,
    input  logic [3:0]        iRound,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iKey_data_1,
    input  logic [DATA_W-1:0] iKey_data_2,
    input  logic [DATA_W-1:0] iKey_data_3,
    input  logic [DATA_W-1:0] iKey_data_4,
    output logic              oBusy,
    output logic              oError,
    output logic              oDone,
    output logic [ADDR_W-1:0] oRAM_Ke_addr,
    output logic              oRAM_Ke_write_1,
    output logic              oRAM_Ke_write_2,
    output logic              oRAM_Ke_write_3,
    output logic              oRAM_Ke_write_4,
    output logic [DATA_W-1:0] oRAM_Ke_data_1,
    output logic [DATA_W-1:0] oRAM_Ke_data_2,
    output logic [DATA_W-1:0] oRAM_Ke_data_3,
    output logic [DATA_W-1:0] oRAM_Ke_data_4,
    output logic [ADDR_W-1:0] oRAM_Kd_addr,
    output logic              oRAM_Kd_write_1,
    output logic              oRAM_Kd_write_2,
    output logic              oRAM_Kd_write_3,
    output logic              oRAM_Kd_write_4,
    output logic [DATA_W-1:0] oRAM_Kd_data_1,
    output logic [DATA_W-1:0] oRAM_Kd_data_2,
    output logic [DATA_W-1:0] oRAM_Kd_data_3,
    output logic [DATA_W-1:0] oRAM_Kd_data_4,
    output logic              oLast_key_data_valid,
    output logic [DATA_W-1:0] oLast_key_data
);
    import rijndael_key_pkg::*;

    function automatic logic [NUM_COLS-1:0] colStrobe(input logic [1:0] idx);
        colStrobe = NUM_COLS'(1) << idx;
    endfunction

    state_e              state;
    state_e              stateNxt;
    logic [1:0]          wordCnt;
    logic [1:0]          wordCntNxt;
    logic [NUM_COLS-1:0] strobeNxt;
    logic                paramOk;

    logic [DATA_W-1:0]   keyWord [NUM_COLS];
    logic [ADDR_W-1:0]   kdAddr;
    logic [NUM_COLS-1:0] keWr;
    logic [NUM_COLS-1:0] kdWr;
    logic                busyQ;
    logic                errQ;
    logic                doneQ;
    logic                lastVldQ;
    logic [DATA_W-1:0]   lastDatQ;

    assign paramOk = (iKC == 4'(SUPPORTED_KC)) && (iBC == 4'(SUPPORTED_BC)) &&
                     (iRound >= 4'd1) && (iRound <= 4'(MAX_ROUNDS));

    always_comb begin
        stateNxt   = state;
        wordCntNxt = wordCnt;
        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNxt   = paramOk ? WRITE : ERR;
                    wordCntNxt = '0;
                end
            end
            WRITE: begin
                if (wordCnt == 2'd3) stateNxt = LAST;
                else                 wordCntNxt = wordCnt + 2'd1;
            end
            LAST:    stateNxt = IDLE;
            ERR:     stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        strobeNxt = (stateNxt == WRITE) ? colStrobe(wordCntNxt) : '0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            wordCnt <= '0;
        end else begin
            state   <= stateNxt;
            wordCnt <= wordCntNxt;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < NUM_COLS; i++) keyWord[i] <= '0;
            kdAddr   <= '0;
            keWr     <= '0;
            kdWr     <= '0;
            busyQ    <= 1'b0;
            errQ     <= 1'b0;
            doneQ    <= 1'b0;
            lastVldQ <= 1'b0;
            lastDatQ <= '0;
        end else begin
            if (state == IDLE && iStart) begin
                keyWord[0] <= iKey_data_1;
                keyWord[1] <= iKey_data_2;
                keyWord[2] <= iKey_data_3;
                keyWord[3] <= iKey_data_4;
                if (paramOk) kdAddr <= ADDR_W'(iRound);
            end
            keWr     <= strobeNxt;
            kdWr     <= strobeNxt;
            busyQ    <= (stateNxt != IDLE);
            errQ     <= (stateNxt == ERR);
            doneQ    <= (stateNxt == LAST) || (stateNxt == ERR);
            lastVldQ <= (stateNxt == LAST);
            if (stateNxt == LAST) lastDatQ <= keyWord[NUM_COLS-1];
        end
    end

    // A four-word key always lands entirely in Ke row 0.
    assign oRAM_Ke_addr         = '0;
    assign oRAM_Kd_addr         = kdAddr;
    assign oBusy                = busyQ;
    assign oError               = errQ;
    assign oDone                = doneQ;
    assign oLast_key_data_valid = lastVldQ;
    assign oLast_key_data       = lastDatQ;

    assign oRAM_Ke_write_1 = keWr[0];
    assign oRAM_Ke_write_2 = keWr[1];
    assign oRAM_Ke_write_3 = keWr[2];
    assign oRAM_Ke_write_4 = keWr[3];
    assign oRAM_Kd_write_1 = kdWr[0];
    assign oRAM_Kd_write_2 = kdWr[1];
    assign oRAM_Kd_write_3 = kdWr[2];
    assign oRAM_Kd_write_4 = kdWr[3];

    assign oRAM_Ke_data_1 = keyWord[0];
    assign oRAM_Ke_data_2 = keyWord[1];
    assign oRAM_Ke_data_3 = keyWord[2];
    assign oRAM_Ke_data_4 = keyWord[3];
    assign oRAM_Kd_data_1 = keyWord[0];
    assign oRAM_Kd_data_2 = keyWord[1];
    assign oRAM_Kd_data_3 = keyWord[2];
    assign oRAM_Kd_data_4 = keyWord[3];

endmodule

// File: tb/tb_first_round_key.sv
// Random and directed stimulus against a cycle-scheduled expectation model of first_round_key.
module tb_first_round_key;
    localparam int NRAND = 2500;
    localparam int NMAX  = NRAND + 300;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iStart = 1'b0;
    logic [3:0]  iKC = 4'd4, iBC = 4'd4, iRound = 4'd10;
    logic [31:0] iKey_data_1 = '0, iKey_data_2 = '0, iKey_data_3 = '0, iKey_data_4 = '0;

    logic        oBusy, oError, oDone, oLast_key_data_valid;
    logic [3:0]  oRAM_Ke_addr, oRAM_Kd_addr;
    logic        oRAM_Ke_write_1, oRAM_Ke_write_2, oRAM_Ke_write_3, oRAM_Ke_write_4;
    logic        oRAM_Kd_write_1, oRAM_Kd_write_2, oRAM_Kd_write_3, oRAM_Kd_write_4;
    logic [31:0] oRAM_Ke_data_1, oRAM_Ke_data_2, oRAM_Ke_data_3, oRAM_Ke_data_4;
    logic [31:0] oRAM_Kd_data_1, oRAM_Kd_data_2, oRAM_Kd_data_3, oRAM_Kd_data_4;
    logic [31:0] oLast_key_data;

    always #5 iClk = ~iClk;

    first_round_key dut (
        .iClk(iClk), .iRst(iRst), .iKC(iKC), .iBC(iBC), .iRound(iRound), .iStart(iStart),
        .iKey_data_1(iKey_data_1), .iKey_data_2(iKey_data_2),
        .iKey_data_3(iKey_data_3), .iKey_data_4(iKey_data_4),
        .oBusy(oBusy), .oError(oError), .oDone(oDone),
        .oRAM_Ke_addr(oRAM_Ke_addr),
        .oRAM_Ke_write_1(oRAM_Ke_write_1), .oRAM_Ke_write_2(oRAM_Ke_write_2),
        .oRAM_Ke_write_3(oRAM_Ke_write_3), .oRAM_Ke_write_4(oRAM_Ke_write_4),
        .oRAM_Ke_data_1(oRAM_Ke_data_1), .oRAM_Ke_data_2(oRAM_Ke_data_2),
        .oRAM_Ke_data_3(oRAM_Ke_data_3), .oRAM_Ke_data_4(oRAM_Ke_data_4),
        .oRAM_Kd_addr(oRAM_Kd_addr),
        .oRAM_Kd_write_1(oRAM_Kd_write_1), .oRAM_Kd_write_2(oRAM_Kd_write_2),
        .oRAM_Kd_write_3(oRAM_Kd_write_3), .oRAM_Kd_write_4(oRAM_Kd_write_4),
        .oRAM_Kd_data_1(oRAM_Kd_data_1), .oRAM_Kd_data_2(oRAM_Kd_data_2),
        .oRAM_Kd_data_3(oRAM_Kd_data_3), .oRAM_Kd_data_4(oRAM_Kd_data_4),
        .oLast_key_data_valid(oLast_key_data_valid), .oLast_key_data(oLast_key_data)
    );

    logic [3:0]  keWrBus, kdWrBus;
    logic [31:0] keDat [4];
    logic [31:0] kdDat [4];
    assign keWrBus  = {oRAM_Ke_write_4, oRAM_Ke_write_3, oRAM_Ke_write_2, oRAM_Ke_write_1};
    assign kdWrBus  = {oRAM_Kd_write_4, oRAM_Kd_write_3, oRAM_Kd_write_2, oRAM_Kd_write_1};
    assign keDat[0] = oRAM_Ke_data_1;
    assign keDat[1] = oRAM_Ke_data_2;
    assign keDat[2] = oRAM_Ke_data_3;
    assign keDat[3] = oRAM_Ke_data_4;
    assign kdDat[0] = oRAM_Kd_data_1;
    assign kdDat[1] = oRAM_Kd_data_2;
    assign kdDat[2] = oRAM_Kd_data_3;
    assign kdDat[3] = oRAM_Kd_data_4;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    // Expected per-cycle pulses, filled in whenever a start is accepted.
    logic [3:0]  expWr   [NMAX];
    logic [3:0]  expKdA  [NMAX];
    bit          expBusy [NMAX];
    bit          expErr  [NMAX];
    bit          expDone [NMAX];
    bit          expLast [NMAX];

    // Persistent values: current expected and the pending update with its start cycle.
    logic [31:0] curKey  [4] = '{default: 32'h0};
    logic [31:0] pendKey [4] = '{default: 32'h0};
    logic [31:0] curLast = '0, pendLast = '0;
    int          keyFrom = -1, lastFrom = -1;
    int          busyEnd = -1;
    int          cyc = -1;

    initial begin
        for (int i = 0; i < NMAX; i++) begin
            expWr[i] = '0; expKdA[i] = '0;
            expBusy[i] = 0; expErr[i] = 0; expDone[i] = 0; expLast[i] = 0;
        end
    end

    task automatic tick(input bit rst, input bit start, input logic [3:0] kc, input logic [3:0] bc,
                        input logic [3:0] rnd, input logic [31:0] k0, input logic [31:0] k1,
                        input logic [31:0] k2, input logic [31:0] k3);
        @(negedge iClk);
        cyc++;
        if (keyFrom == cyc)  curKey  = pendKey;
        if (lastFrom == cyc) curLast = pendLast;

        checkVal("ke_wr",    32'(keWrBus), 32'(expWr[cyc]));
        checkVal("kd_wr",    32'(kdWrBus), 32'(expWr[cyc]));
        checkVal("busy",     32'(oBusy), 32'(expBusy[cyc]));
        checkVal("error",    32'(oError), 32'(expErr[cyc]));
        checkVal("done",     32'(oDone), 32'(expDone[cyc]));
        checkVal("last_vld", 32'(oLast_key_data_valid), 32'(expLast[cyc]));
        checkVal("last_dat", oLast_key_data, curLast);
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("ke_dat%0d", k + 1), keDat[k], curKey[k]);
            checkVal($sformatf("kd_dat%0d", k + 1), kdDat[k], curKey[k]);
        end
        if (expWr[cyc] != 4'd0) begin
            checkVal("ke_addr", 32'(oRAM_Ke_addr), 32'd0);
            checkVal("kd_addr", 32'(oRAM_Kd_addr), 32'(expKdA[cyc]));
        end

        iRst = rst; iStart = start; iKC = kc; iBC = bc; iRound = rnd;
        iKey_data_1 = k0; iKey_data_2 = k1; iKey_data_3 = k2; iKey_data_4 = k3;

        if (rst) begin
            for (int i = cyc + 1; i <= cyc + 6; i++) begin
                expWr[i] = '0; expBusy[i] = 0; expErr[i] = 0; expDone[i] = 0; expLast[i] = 0;
            end
            busyEnd  = cyc;
            keyFrom  = cyc + 1; pendKey = '{default: 32'h0};
            lastFrom = cyc + 1; pendLast = '0;
        end else if (start && cyc > busyEnd) begin
            keyFrom = cyc + 1;
            pendKey = '{k0, k1, k2, k3};
            if (kc == 4'd4 && bc == 4'd4 && rnd >= 4'd1 && rnd <= 4'd14) begin
                for (int t = 0; t < 4; t++) begin
                    expWr[cyc + 1 + t]  = 4'(1 << t);
                    expKdA[cyc + 1 + t] = rnd;
                end
                for (int i = 1; i <= 5; i++) expBusy[cyc + i] = 1;
                expDone[cyc + 5] = 1;
                expLast[cyc + 5] = 1;
                lastFrom = cyc + 5;
                pendLast = k3;
                busyEnd  = cyc + 5;
            end else begin
                expBusy[cyc + 1] = 1;
                expErr[cyc + 1]  = 1;
                expDone[cyc + 1] = 1;
                busyEnd = cyc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(0, 0, 4'd4, 4'd4, 4'd10, $urandom, $urandom, $urandom, $urandom);
    endtask

    localparam logic [31:0] F0 = 32'h2b7e1516, F1 = 32'h28aed2a6;
    localparam logic [31:0] F2 = 32'habf71588, F3 = 32'h09cf4f3c;
    localparam logic [31:0] ONES = 32'hffffffff;

    initial begin
        repeat (3) tick(1, 0, 4'd4, 4'd4, 4'd10, '0, '0, '0, '0);

        // FIPS-197 key, then unsupported parameters.
        tick(0, 1, 4'd4, 4'd4, 4'd10, F0, F1, F2, F3);
        idle(6);
        tick(0, 1, 4'd6, 4'd4, 4'd10, F0, F1, F2, F3);
        idle(3);
        tick(0, 1, 4'd4, 4'd4, 4'd0, F0, F1, F2, F3);
        idle(3);
        tick(0, 1, 4'd4, 4'd4, 4'd15, F0, F1, F2, F3);
        idle(3);

        // Key inputs forced to all-ones while the latched key is being written.
        tick(0, 1, 4'd4, 4'd4, 4'd14, F0, F1, F2, F3);
        repeat (5) tick(0, 0, 4'd4, 4'd4, 4'd10, ONES, ONES, ONES, ONES);
        idle(2);

        // Restarts while busy are dropped; the first cycle back in idle is accepted.
        tick(0, 1, 4'd4, 4'd4, 4'd10, F0, F1, F2, F3);
        idle(1);
        tick(0, 1, 4'd4, 4'd4, 4'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        idle(2);
        tick(0, 1, 4'd4, 4'd4, 4'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tick(0, 1, 4'd4, 4'd4, 4'd1, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
        idle(7);

        // Reset in the middle of the write burst, then a clean operation.
        tick(0, 1, 4'd4, 4'd4, 4'd10, F0, F1, F2, F3);
        idle(1);
        tick(1, 0, 4'd4, 4'd4, 4'd10, F0, F1, F2, F3);
        idle(2);
        tick(0, 1, 4'd4, 4'd4, 4'd12, F3, F2, F1, F0);
        idle(7);

        for (int i = 0; i < NRAND; i++) begin
            bit          r, s;
            logic [3:0]  kc, bc, rnd;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 3) == 0);
            kc  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd4;
            bc  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd4;
            rnd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 14));
            tick(r, s, kc, bc, rnd, $urandom, $urandom, $urandom, $urandom);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
